// File: rtl/conv_acc_relu.sv
// Per-lane accumulation of CNT_LAST+1 samples, bias add, shift, ReLU and saturation into a result register.
// Result is valid 1 cycle after the closing sample; stall is raised while the result waits for out_ready.
module conv_acc_relu #(
    parameter int LANES    = 16,
    parameter int IN_W     = 32,
    parameter int OUT_W    = 16,
    parameter int CNT_LAST = 31,
    parameter int SHIFT    = 8
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   en,
    input  logic [4:0]             cnt_in,
    input  logic [3:0]             pos_in,
    input  logic [LANES*IN_W-1:0]  input_data,
    input  logic [LANES*16-1:0]    bias_data,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [3:0]             out_pos,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   stall,
    output logic                   seq_err,
    output logic                   drop_err
);

    localparam int ACC_W = IN_W + 5;
    localparam int SUM_W = ((ACC_W > 16 + SHIFT) ? ACC_W : 16 + SHIFT) + 2;
    localparam logic signed [SUM_W-1:0] MAX_T = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

    typedef enum logic {IDLE, ACC} state_t;

    state_t                        state, state_nxt;
    logic [4:0]                    exp_cnt;
    logic [3:0]                    grp_pos;
    logic [LANES-1:0][ACC_W-1:0]   acc;
    logic [LANES-1:0][ACC_W-1:0]   in_ext;
    logic [LANES*OUT_W-1:0]        result;
    logic                          accept, in_seq;
    logic                          do_start, do_add, do_close, set_seq;

    assign stall  = out_valid && !out_ready;
    assign accept = en && !stall;
    assign in_seq = (state == ACC) && (cnt_in == exp_cnt) && (pos_in == grp_pos);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (cnt_in == 5'd0)                           state_nxt = ACC;
            else if (!in_seq)                             state_nxt = IDLE;
            else if (cnt_in == 5'(CNT_LAST))              state_nxt = IDLE;
        end
    end

    always_comb begin
        do_start = 1'b0;
        do_add   = 1'b0;
        do_close = 1'b0;
        set_seq  = 1'b0;
        if (accept) begin
            if (cnt_in == 5'd0) begin
                do_start = 1'b1;
                set_seq  = (state == ACC);   // restarting discards the open group
            end else if (in_seq) begin
                if (cnt_in == 5'(CNT_LAST)) do_close = 1'b1;
                else                        do_add   = 1'b1;
            end else begin
                set_seq = 1'b1;
            end
        end
    end

    // Lane 0 sits at the MSB end of every packed bus.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IN_W-1:0]         lane;
        logic [15:0]             b;
        logic signed [SUM_W-1:0] t;

        assign lane      = input_data[(LANES-1-k)*IN_W +: IN_W];
        assign b         = bias_data[(LANES-1-k)*16 +: 16];
        assign in_ext[k] = {{(ACC_W-IN_W){lane[IN_W-1]}}, lane};
        assign t = ($signed({{(SUM_W-ACC_W){acc[k][ACC_W-1]}}, acc[k]})
                  + $signed({{(SUM_W-ACC_W){in_ext[k][ACC_W-1]}}, in_ext[k]})
                  + ($signed({{(SUM_W-16){b[15]}}, b}) <<< SHIFT)) >>> SHIFT;
        assign result[(LANES-1-k)*OUT_W +: OUT_W] =
            t[SUM_W-1] ? '0 : (t > MAX_T) ? {1'b0, {(OUT_W-1){1'b1}}} : t[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc       <= '0;
            exp_cnt   <= '0;
            grp_pos   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pos   <= '0;
            seq_err   <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            if (do_start) begin
                for (int k = 0; k < LANES; k++) acc[k] <= in_ext[k];
                exp_cnt <= 5'd1;
                grp_pos <= pos_in;
            end else if (do_add) begin
                for (int k = 0; k < LANES; k++) acc[k] <= acc[k] + in_ext[k];
                exp_cnt <= exp_cnt + 5'd1;
            end else if (do_close) begin
                exp_cnt <= '0;
            end
            if (set_seq)      seq_err  <= 1'b1;
            if (en && stall)  drop_err <= 1'b1;
            // A load can only happen when not stalled, so it never overwrites a held result.
            if (do_close) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_pos   <= grp_pos;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_acc_relu.sv
// Scoreboard bench for conv_acc_relu: expected lanes queued at the closing sample, compared when out_valid rises.
module tb_conv_acc_relu;
    localparam int LANES    = 16;
    localparam int IN_W     = 32;
    localparam int OUT_W    = 16;
    localparam int CNT_LAST = 31;
    localparam int SHIFT    = 8;
    localparam longint MAXV = (64'sd1 <<< (OUT_W-1)) - 1;

    logic                   clk = 1'b0;
    logic                   rst_b, en, out_ready;
    logic [4:0]             cnt_in;
    logic [3:0]             pos_in;
    logic [LANES*IN_W-1:0]  input_data;
    logic [LANES*16-1:0]    bias_data;
    logic                   out_valid, stall, seq_err, drop_err;
    logic [3:0]             out_pos;
    logic [LANES*OUT_W-1:0] out_data;

    int assertions = 0;
    int failures   = 0;

    typedef struct packed {
        logic [3:0]             pos;
        logic [LANES*OUT_W-1:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t last_exp;

    conv_acc_relu #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_LAST(CNT_LAST), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_b(rst_b), .en(en), .cnt_in(cnt_in), .pos_in(pos_in),
        .input_data(input_data), .bias_data(bias_data), .out_ready(out_ready),
        .out_valid(out_valid), .out_pos(out_pos), .out_data(out_data),
        .stall(stall), .seq_err(seq_err), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [OUT_W-1:0] model_lane(input longint s, input longint b);
        longint t;
        t = (s + (b <<< SHIFT)) >>> SHIFT;
        if (t < 0)    return '0;
        if (t > MAXV) return MAXV[OUT_W-1:0];
        return t[OUT_W-1:0];
    endfunction

    task automatic drive_group(input logic [3:0] pos, input int cval, input bit rnd,
                               input int bias, input int last_cnt);
        longint sums[LANES];
        exp_t   e;
        for (int k = 0; k < LANES; k++) sums[k] = 0;
        for (int c = 0; c <= last_cnt; c++) begin
            @(negedge clk);
            for (int k = 0; k < LANES; k++) begin
                int v;
                v = rnd ? (int'($urandom_range(2097152, 0)) - 1048576) : cval;
                sums[k] += v;
                input_data[(LANES-1-k)*IN_W +: IN_W] = v;
                bias_data[(LANES-1-k)*16 +: 16]     = bias[15:0];
            end
            en     = 1'b1;
            cnt_in = c[4:0];
            pos_in = pos;
            if (c == CNT_LAST) begin
                e.pos = pos;
                for (int k = 0; k < LANES; k++)
                    e.data[(LANES-1-k)*OUT_W +: OUT_W] = model_lane(sums[k], bias);
                sb.push_back(e);
            end
        end
        @(negedge clk);
        en = 1'b0;
        if (last_cnt == CNT_LAST) begin
            assertions++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL latency: out_valid=%b one cycle after closing sample, expected 1", out_valid);
            end
        end
    endtask

    task automatic check_result(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        assertions++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL %s_valid: out_valid=%b queued=%0d, expected valid with a queued result", name, out_valid, sb.size());
        end else begin
            last_exp = sb.pop_front();
            assertions++;
            if (out_pos !== last_exp.pos) begin
                failures++;
                $display("FAIL %s_pos: got %0d expected %0d", name, out_pos, last_exp.pos);
            end
            assertions++;
            if (out_data !== last_exp.data) begin
                failures++;
                $display("FAIL %s_data: got %h expected %h", name, out_data, last_exp.data);
            end
        end
    endtask

    task automatic send_sample(input logic [4:0] c, input logic [3:0] pos, input int val);
        @(negedge clk);
        for (int k = 0; k < LANES; k++) input_data[(LANES-1-k)*IN_W +: IN_W] = val;
        bias_data = '0;
        en = 1'b1; cnt_in = c; pos_in = pos;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; en = 1'b0; cnt_in = '0; pos_in = '0;
        input_data = '0; bias_data = '0; out_ready = 1'b1;
        #3;
        assertions++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        assertions++; if (out_data !== '0)    begin failures++; $display("FAIL reset_data: got %h expected 0", out_data); end
        assertions++; if (out_pos !== 4'd0)   begin failures++; $display("FAIL reset_pos: got %0d expected 0", out_pos); end
        assertions++; if (seq_err !== 1'b0)   begin failures++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
        assertions++; if (drop_err !== 1'b0)  begin failures++; $display("FAIL reset_drop_err: got %b expected 0", drop_err); end
        assertions++; if (stall !== 1'b0)     begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_basic();
        drive_group(4'd3, 256, 1'b0, 0, CNT_LAST);
        check_result("basic");
        assertions++;
        if (last_exp.data[OUT_W-1:0] !== 16'd32) begin
            failures++; $display("FAIL basic_model: model lane gives %0d expected 32", last_exp.data[OUT_W-1:0]);
        end
        @(negedge clk);
        assertions++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_clear: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_relu_sat();
        drive_group(4'd1, -256, 1'b0, 0, CNT_LAST);
        check_result("relu_neg");
        drive_group(4'd2, 32'h0010_0000, 1'b0, 0, CNT_LAST);
        check_result("saturate");
    endtask

    task automatic test_bias();
        drive_group(4'd4, 0, 1'b0, 5, CNT_LAST);
        check_result("bias_pos");
        drive_group(4'd0, 0, 1'b0, -1, CNT_LAST);
        check_result("bias_neg");
    endtask

    task automatic test_stall();
        @(negedge clk);
        out_ready = 1'b0;
        drive_group(4'd7, 300, 1'b0, 2, CNT_LAST);
        check_result("stall_load");
        en = 1'b1; cnt_in = 5'd5; pos_in = 4'd3;
        #1;
        assertions++;
        if (stall !== 1'b1) begin failures++; $display("FAIL stall_flag: got %b expected 1", stall); end
        @(negedge clk);
        en = 1'b0;
        assertions++;
        if (drop_err !== 1'b1) begin failures++; $display("FAIL drop_err: got %b expected 1", drop_err); end
        assertions++;
        if (out_valid !== 1'b1 || out_data !== last_exp.data || out_pos !== last_exp.pos) begin
            failures++;
            $display("FAIL stall_hold: valid=%b pos=%0d data=%h expected valid with pos=%0d data=%h",
                     out_valid, out_pos, out_data, last_exp.pos, last_exp.data);
        end
        assertions++;
        if (seq_err !== 1'b0) begin failures++; $display("FAIL drop_no_effect: seq_err=%b expected 0", seq_err); end
        out_ready = 1'b1;
        @(negedge clk);
        assertions++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_release: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_seq_err();
        send_sample(5'd0, 4'd2, 100);
        send_sample(5'd1, 4'd2, 100);
        assertions++;
        if (seq_err !== 1'b0) begin failures++; $display("FAIL seq_in_order: seq_err=%b expected 0", seq_err); end
        send_sample(5'd3, 4'd2, 100);
        assertions++;
        if (seq_err !== 1'b1) begin failures++; $display("FAIL seq_skip: seq_err=%b expected 1", seq_err); end
        send_sample(5'd4, 4'd2, 100);
        assertions++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL seq_no_result: out_valid=%b expected 0", out_valid); end
        drive_group(4'd5, 512, 1'b0, 0, CNT_LAST);
        check_result("seq_recover");
    endtask

    task automatic test_reset_mid();
        drive_group(4'd6, 1000, 1'b0, 0, 15);
        #2;
        rst_b = 1'b0;
        #1;
        assertions++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_pos !== 4'd0 ||
            seq_err !== 1'b0 || drop_err !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: valid=%b pos=%0d seq=%b drop=%b stall=%b data=%h expected all 0",
                     out_valid, out_pos, seq_err, drop_err, stall, out_data);
        end
        @(negedge clk);
        rst_b = 1'b1;
        drive_group(4'd8, 256, 1'b0, 3, CNT_LAST);
        check_result("after_reset");
    endtask

    task automatic test_back_to_back();
        drive_group(4'd1, 0, 1'b1, int'($urandom_range(2000, 0)) - 1000, CNT_LAST);
        check_result("random_a");
        drive_group(4'd6, 0, 1'b1, int'($urandom_range(2000, 0)) - 1000, CNT_LAST);
        check_result("random_b");
        assertions++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d left expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu_sat();
        test_bias();
        test_stall();
        test_seq_err();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
